// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: PC width, NOP word,
// fetch FSM encodings and the queue entry layout.
package fetch_pc_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pcp1;
  } fq_entry_t;

  // Word-address increment; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_queue.sv
// Small synchronous FIFO holding fetched {instruction, PC+1} pairs.
// Flush wins over push/pop; simultaneous push and pop keep the count.
module fetch_queue
  import fetch_pc_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  fq_entry_t        data_i,
  output fq_entry_t        head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge CLK) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, issues single-outstanding word reads, queues the
// returned words and presents the head entry (or a NOP) to the IF/ID register.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCBranch,
  output logic        IMReq,
  output logic [31:0] IMAddr,
  input  logic        IMAck,
  input  logic [31:0] IMData,
  output logic [31:0] IMRD,
  output logic [31:0] PCp1,
  output logic        FetchValid
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             push, pop, empty;
  logic [CNT_W-1:0] count;
  fq_entry_t        head, push_data;

  // With one request in flight at most, REQ implies nothing outstanding, so
  // the queue count alone decides whether the returned word will fit.
  assign IMReq  = !RST && (state_q == ST_REQ) && (count < CNT_W'(DEPTH)) && !PCSrc;
  assign IMAddr = pc_q;

  assign push            = (state_q == ST_WAIT) && IMAck && !PCSrc;
  assign pop             = !Stall && !empty && !PCSrc;
  assign push_data.instr = IMData;
  assign push_data.pcp1  = pc_inc(req_pc_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (PCSrc)      pc_d = PCBranch;
    else if (IMReq) pc_d = pc_inc(pc_q);
    if (IMReq) req_pc_d = pc_q;
    case (state_q)
      ST_REQ:     if (IMReq) state_d = ST_WAIT;
      // A redirect while waiting must swallow the in-flight word unless it
      // arrives in that same cycle, where it is simply not pushed.
      ST_WAIT: begin
        if (IMAck)      state_d = ST_REQ;
        else if (PCSrc) state_d = ST_DISCARD;
      end
      ST_DISCARD: if (IMAck) state_d = ST_REQ;
      default:    state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .CLK     (CLK),
    .RST     (RST),
    .flush_i (PCSrc),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .head_o  (head),
    .empty_o (empty),
    .count_o (count)
  );

  assign FetchValid = !empty;
  assign IMRD       = empty ? NOP_INSTR : head.instr;
  assign PCp1       = empty ? NOP_INSTR : head.pcp1;

endmodule
